// File: rtl/pll_cfg_seq.sv
// Reprograms the SNES clock PLL reconfig core for the NTSC or PAL profile over
// Avalon-MM, issues start, then waits for a stable relock or a timeout.
`timescale 1ns/1ps
module pll_cfg_seq #(
    parameter logic [31:0] K_NTSC       = 32'h9745BF27,
    parameter logic [31:0] K_PAL        = 32'h83365882,
    parameter logic [23:0] LOCK_TIMEOUT = 24'd1000000,
    parameter int unsigned LOCK_STABLE  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel_i,
    input  logic        force_i,
    input  logic        locked_i,
    input  logic        mgmt_waitrequest_i,
    output logic [5:0]  mgmt_address_o,
    output logic        mgmt_write_o,
    output logic [31:0] mgmt_writedata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        cur_sel_o
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_LOCKWAIT, S_FIN} state_t;

    localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);

    state_t              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic                tsel_q, tsel_d;
    logic                err_q, err_d;
    logic                cur_sel_q, cur_sel_d;
    logic [23:0]         tmo_q, tmo_d;
    logic [STAB_W-1:0]   stab_q, stab_d;
    logic                lock_meta_q, lock_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            tsel_q      <= 1'b0;
            err_q       <= 1'b0;
            cur_sel_q   <= 1'b0;
            tmo_q       <= '0;
            stab_q      <= '0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tsel_q      <= tsel_d;
            err_q       <= err_d;
            cur_sel_q   <= cur_sel_d;
            tmo_q       <= tmo_d;
            stab_q      <= stab_d;
            lock_meta_q <= locked_i;
            lock_sync_q <= lock_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tsel_d    = tsel_q;
        err_d     = err_q;
        cur_sel_d = cur_sel_q;
        tmo_d     = tmo_q;
        stab_d    = stab_q;
        case (state_q)
            S_IDLE: begin
                if ((sel_i != cur_sel_q) || force_i) begin
                    state_d = S_WRITE;
                    tsel_d  = sel_i;
                    err_d   = 1'b0;
                    idx_d   = '0;
                end
            end
            S_WRITE: begin
                if (!mgmt_waitrequest_i) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_LOCKWAIT;
                        tmo_d   = '0;
                        stab_d  = '0;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                idx_d   = idx_q + 3'd1;
                state_d = S_WRITE;
            end
            S_LOCKWAIT: begin
                tmo_d  = tmo_q + 24'd1;
                stab_d = lock_sync_q ? stab_q + STAB_W'(1) : '0;
                // Lock is tested first so it wins a tie with the timeout.
                if (stab_d == STAB_W'(LOCK_STABLE)) begin
                    state_d = S_FIN;
                end else if (tmo_d == LOCK_TIMEOUT) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end
            end
            S_FIN: begin
                cur_sel_d = tsel_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from registered state, so reset clears them immediately.
    always_comb begin
        mgmt_write_o     = 1'b0;
        mgmt_address_o   = '0;
        mgmt_writedata_o = '0;
        if (state_q == S_WRITE) begin
            mgmt_write_o = 1'b1;
            case (idx_q)
                3'd0: begin mgmt_address_o = 6'd0; mgmt_writedata_o = 32'h0000_0001; end
                3'd1: begin mgmt_address_o = 6'd4; mgmt_writedata_o = 32'h0000_0404; end
                3'd2: begin mgmt_address_o = 6'd7; mgmt_writedata_o = tsel_q ? K_PAL : K_NTSC; end
                3'd3: begin mgmt_address_o = 6'd5; mgmt_writedata_o = 32'h0002_0302; end
                3'd4: begin mgmt_address_o = 6'd5; mgmt_writedata_o = 32'h0004_0505; end
                3'd5: begin mgmt_address_o = 6'd5; mgmt_writedata_o = 32'h0008_0A0A; end
                3'd6: begin mgmt_address_o = 6'd5; mgmt_writedata_o = 32'h000C_3C3C; end
                default: begin mgmt_address_o = 6'd2; mgmt_writedata_o = 32'h0000_0000; end
            endcase
        end
        busy_o    = (state_q != S_IDLE);
        done_o    = (state_q == S_FIN);
        err_o     = err_q;
        cur_sel_o = cur_sel_q;
    end
endmodule

// File: tb/tb_pll_cfg_seq.sv
// Bench for pll_cfg_seq: directed scenarios plus randomized profile requests,
// checked against a list-level model of the expected register writes.
`timescale 1ns/1ps
module tb_pll_cfg_seq;
    localparam logic [31:0] K_NTSC_C = 32'h9745BF27;
    localparam logic [31:0] K_PAL_C  = 32'h83365882;
    localparam int STABLE = 16;
    localparam int TMO    = 100;

    logic        clk = 1'b0;
    logic        rst_n, sel, force_p, locked, wreq;
    logic [5:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        busy, done, err, cur_sel;

    int errors = 0;
    int checks = 0;

    int unsigned acc_addr[$];
    logic [31:0] acc_data[$];
    int   cyc = 0, start_cyc = 0, done_cnt = 0, done_lat = 0, wr_cycles = 0;
    logic done_err = 1'b0;
    bit   rand_wreq = 1'b0;

    int unsigned ref_addr[8];
    logic [31:0] ref_data[8];

    pll_cfg_seq #(.LOCK_TIMEOUT(24'd100), .LOCK_STABLE(16)) dut (
        .clk(clk), .rst_n(rst_n), .sel_i(sel), .force_i(force_p), .locked_i(locked),
        .mgmt_waitrequest_i(wreq), .mgmt_address_o(addr), .mgmt_write_o(wr),
        .mgmt_writedata_o(wdata), .busy_o(busy), .done_o(done), .err_o(err),
        .cur_sel_o(cur_sel)
    );

    always #5 clk = ~clk;

    // Bus monitor: records every accepted write and every done pulse.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n && wr) wr_cycles = wr_cycles + 1;
        if (rst_n && wr && !wreq) begin
            acc_addr.push_back(32'(addr));
            acc_data.push_back(wdata);
            if (addr == 6'd2) start_cyc = cyc;
        end
        if (rst_n && done) begin
            done_cnt = done_cnt + 1;
            done_err = err;
            done_lat = cyc - start_cyc;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_wreq) wreq = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int i, input bit p);
        if (i == 2) return p ? K_PAL_C : K_NTSC_C;
        return ref_data[i];
    endfunction

    task automatic wait_done(input int dbase, input int budget, input string tag);
        int n = 0;
        while (done_cnt <= dbase && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt > dbase), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_writes(input int base, input bit p, input string tag);
        chk({tag, "_write_count"}, 32'(acc_addr.size() - base), 32'd8);
        if (acc_addr.size() >= base + 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("%s_addr%0d", tag, i), acc_addr[base + i], ref_addr[i]);
                chk($sformatf("%s_data%0d", tag, i), acc_data[base + i], exp_data(i, p));
            end
        end
    endtask

    task automatic kick(input bit s, input bit f);
        @(posedge clk);
        #1;
        sel = s;
        force_p = f;
        @(posedge clk);
        #1;
        force_p = 1'b0;
    endtask

    initial begin
        int  base, dbase, n;
        bit  model_cur, s, f;

        ref_addr = '{0, 4, 7, 5, 5, 5, 5, 2};
        ref_data = '{32'h1, 32'h404, 32'h0, 32'h00020302, 32'h00040505,
                     32'h00080A0A, 32'h000C3C3C, 32'h0};

        // Reset state and idle with sel=0
        rst_n = 1'b0; sel = 1'b0; force_p = 1'b0; locked = 1'b1; wreq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_write", 32'(wr), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data", wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cur_sel", 32'(cur_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("idle_write_cycles", 32'(wr_cycles), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_cur_sel", 32'(cur_sel), 32'd0);
        chk("idle_done_cnt", 32'(done_cnt), 32'd0);
        model_cur = 1'b0;

        // Switch to PAL with no waitrequest
        base = acc_addr.size(); dbase = done_cnt;
        kick(1'b1, 1'b0);
        wait_done(dbase, 300, "pal");
        check_writes(base, 1'b1, "pal");
        chk("pal_lock_latency", 32'(done_lat), 32'(STABLE + 1));
        chk("pal_done_err", 32'(done_err), 32'd0);
        chk("pal_cur_sel", 32'(cur_sel), 32'd1);
        chk("pal_busy_after", 32'(busy), 32'd0);
        model_cur = 1'b1;

        // Waitrequest stall on write index 3
        base = acc_addr.size(); dbase = done_cnt;
        kick(1'b1, 1'b1);
        n = 0;
        while (acc_addr.size() < base + 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1 wreq = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_write", i), 32'(wr), 32'd1);
            chk($sformatf("stall%0d_addr", i), 32'(addr), 32'd5);
            chk($sformatf("stall%0d_data", i), wdata, 32'h00020302);
            if (i < 5) begin
                @(posedge clk);
                #1;
                if (i == 4) wreq = 1'b0;
            end
        end
        wait_done(dbase, 300, "stall");
        check_writes(base, 1'b1, "stall");
        chk("stall_cur_sel", 32'(cur_sel), 32'd1);

        // sel 1->0->1 and a force pulse during busy: no second sequence
        base = acc_addr.size(); dbase = done_cnt;
        kick(1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1 sel = 1'b0; force_p = 1'b1;
        @(posedge clk);
        #1 force_p = 1'b0;
        repeat (4) @(posedge clk);
        #1 sel = 1'b1;
        wait_done(dbase, 300, "toggle_back");
        repeat (30) @(posedge clk);
        @(negedge clk);
        check_writes(base, 1'b1, "toggle_back");
        chk("toggle_back_done_cnt", 32'(done_cnt), 32'(dbase + 1));
        chk("toggle_back_cur_sel", 32'(cur_sel), 32'd1);
        chk("toggle_back_busy", 32'(busy), 32'd0);

        // sel left at 0 during busy: queued NTSC sequence follows
        base = acc_addr.size(); dbase = done_cnt;
        kick(1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1 sel = 1'b0;
        wait_done(dbase, 300, "queued_first");
        check_writes(base, 1'b1, "queued_first");
        chk("queued_first_cur_sel", 32'(cur_sel), 32'd1);
        wait_done(dbase + 1, 300, "queued_second");
        check_writes(base + 8, 1'b0, "queued_second");
        chk("queued_second_cur_sel", 32'(cur_sel), 32'd0);
        model_cur = 1'b0;

        // Random profile requests with random waitrequest
        rand_wreq = 1'b1;
        for (int it = 0; it < 8; it++) begin
            s = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 3) == 0);
            base = acc_addr.size(); dbase = done_cnt;
            kick(s, f);
            if (s != model_cur || f) begin
                wait_done(dbase, 1000, $sformatf("rnd%0d", it));
                check_writes(base, s, $sformatf("rnd%0d", it));
                chk($sformatf("rnd%0d_cur_sel", it), 32'(cur_sel), 32'(s));
                chk($sformatf("rnd%0d_lock_latency", it), 32'(done_lat), 32'(STABLE + 1));
                model_cur = s;
            end else begin
                repeat (20) @(posedge clk);
                @(negedge clk);
                chk($sformatf("rnd%0d_no_writes", it), 32'(acc_addr.size() - base), 32'd0);
                chk($sformatf("rnd%0d_no_done", it), 32'(done_cnt), 32'(dbase));
            end
        end
        rand_wreq = 1'b0;
        @(posedge clk);
        #2 wreq = 1'b0;

        // Lock never arrives: timeout, sticky err, no retry
        locked = 1'b0;
        repeat (4) @(posedge clk);
        base = acc_addr.size(); dbase = done_cnt;
        kick(model_cur, 1'b1);
        wait_done(dbase, 400, "tmo");
        check_writes(base, model_cur, "tmo");
        chk("tmo_done_err", 32'(done_err), 32'd1);
        chk("tmo_latency", 32'(done_lat), 32'(TMO + 1));
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("tmo_err_sticky", 32'(err), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_cur_sel", 32'(cur_sel), 32'(model_cur));
        chk("tmo_no_retry", 32'(done_cnt), 32'(dbase + 1));
        locked = 1'b1;
        repeat (4) @(posedge clk);
        dbase = done_cnt;
        kick(model_cur, 1'b1);
        chk("tmo_err_cleared", 32'(err), 32'd0);
        chk("tmo_restart_busy", 32'(busy), 32'd1);
        wait_done(dbase, 300, "tmo_recover");
        chk("tmo_recover_done_err", 32'(done_err), 32'd0);
        chk("tmo_recover_err", 32'(err), 32'd0);

        // Reset during write index 4, restart from index 0 with sel=1
        base = acc_addr.size();
        kick(1'b1, 1'b1);
        n = 0;
        while (acc_addr.size() < base + 4 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1 wreq = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_write_pre", 32'(wr), 32'd1);
        chk("mid_addr_pre", 32'(addr), 32'd5);
        chk("mid_data_pre", wdata, 32'h00040505);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_write", 32'(wr), 32'd0);
        chk("mid_rst_addr", 32'(addr), 32'd0);
        chk("mid_rst_data", wdata, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_cur_sel", 32'(cur_sel), 32'd0);
        wreq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = acc_addr.size(); dbase = done_cnt;
        wait_done(dbase, 300, "restart");
        check_writes(base, 1'b1, "restart");
        chk("restart_cur_sel", 32'(cur_sel), 32'd1);
        chk("restart_err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
